uart_core_param: RTL

Parametrised UART peripheral: programmable baud divisor, 5–8-bit data, optional even/odd parity, 1 or 2 stop bits, loopback, sticky error flags and an interrupt output. TX and RX FIFOs of configurable depth are internal. Sits on the system bus through the same single-strobe register slave handshake as the existing UART and replaces it in new designs.

---
 rtl/uart_core_param.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_core_param.sv
// Parametrised UART peripheral: single-strobe register slave, internal TX/RX FIFOs,
// programmable baud prescaler (16 ticks per bit), parity, 1/2 stop bits and loopback.

module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module uart_core_param #(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd26
) (
  input  logic       i_sys_clk,
  input  logic       i_arst_n,
  input  logic       i_cyc,
  input  logic       i_stb,
  input  logic       i_we,
  input  logic [2:0] i_add,
  input  logic [7:0] i_data_in,
  output logic       o_ack,
  output logic [7:0] o_data_out,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  typedef struct packed {
    logic tx_ie, rx_ie, loopback, two_stop, par_odd, par_en, rx_en, tx_en;
  } ctrl_t;

  logic [1:0]  rst_sync;
  logic        rst_n;
  ctrl_t       ctrl;
  logic [15:0] div, presc;
  logic        tick, accept, wr, rd;
  logic [7:0]  rdata, status;
  logic        rx_ovr, frame_err, par_err;

  logic [CW-1:0]     tx_count, rx_count;
  logic [DATA_W-1:0] tx_dout, rx_dout;
  logic              tx_empty, tx_full, rx_empty, rx_full, rx_pop;

  state_t            tx_state, tx_next, rx_state, rx_next;
  logic [3:0]        tx_cnt, rx_cnt;
  logic [2:0]        tx_bit_idx, rx_bit_idx;
  logic [DATA_W-1:0] tx_shift, rx_shift;
  logic              tx_par_en, tx_two_stop, tx_par_bit, tx_stop_idx;
  logic              tx_line, tx_pop, tx_bit_end;
  logic [1:0]        rx_sync;
  logic              rx_s, rx_sample, rx_par_bad, rx_done, rx_good;

  // Reset asserts asynchronously and is released on a clock edge.
  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign accept = i_cyc & i_stb & ~o_ack;
  assign wr     = accept & i_we;
  assign rd     = accept & ~i_we;
  assign rx_pop = rd & (i_add == 3'd0);

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
  assign status   = {par_err, frame_err, rx_ovr, tx_state == S_IDLE, tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    rdata = 8'h00;
    case (i_add)
      3'd0:    rdata = rx_empty ? 8'h00 : 8'(rx_dout);
      3'd1:    rdata = ctrl;
      3'd2:    rdata = status;
      3'd3:    rdata = div[7:0];
      3'd4:    rdata = div[15:8];
      3'd5:    rdata = 8'(rx_count);
      default: rdata = 8'h00;
    endcase
  end

  uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(i_sys_clk), .rst_n(rst_n), .push(wr & (i_add == 3'd0)), .pop(tx_pop),
    .din(i_data_in[DATA_W-1:0]), .dout(tx_dout), .count(tx_count)
  );

  uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(i_sys_clk), .rst_n(rst_n), .push(rx_good), .pop(rx_pop),
    .din(rx_shift), .dout(rx_dout), .count(rx_count)
  );

  assign tick = (presc == div);

  // Registers, prescaler, sticky flags (set beats W1C) and the registered interrupt.
  always_ff @(posedge i_sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ack      <= 1'b0;
      o_data_out <= 8'h00;
      ctrl       <= '0;
      div        <= DIV_RESET;
      presc      <= '0;
      rx_ovr     <= 1'b0;
      frame_err  <= 1'b0;
      par_err    <= 1'b0;
      o_irq      <= 1'b0;
    end else begin
      o_ack      <= accept;
      o_data_out <= rd ? rdata : 8'h00;
      if (wr && i_add == 3'd1) ctrl <= ctrl_t'(i_data_in);
      if (wr && i_add == 3'd3) div[7:0] <= i_data_in;
      if (wr && i_add == 3'd4) div[15:8] <= i_data_in;
      presc <= (tick || (wr && (i_add == 3'd3 || i_add == 3'd4))) ? 16'd0 : presc + 16'd1;
      rx_ovr    <= (rx_good & rx_full & ~rx_pop) | (rx_ovr & ~(wr && i_add == 3'd2 && i_data_in[5]));
      frame_err <= (rx_done & ~rx_s) | (frame_err & ~(wr && i_add == 3'd2 && i_data_in[6]));
      par_err   <= (rx_done & rx_par_bad) | (par_err & ~(wr && i_add == 3'd2 && i_data_in[7]));
      o_irq <= (ctrl.rx_ie & ~rx_empty) | (ctrl.tx_ie & tx_empty) | rx_ovr | frame_err | par_err;
    end
  end

  assign tx_bit_end = tick && (tx_cnt == 4'd15);

  always_ff @(posedge i_sys_clk or negedge rst_n) begin
    if (!rst_n) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_next = tx_state;
    tx_line = 1'b1;
    case (tx_state)
      S_IDLE:   if (tick && ctrl.tx_en && !tx_empty) tx_next = S_START;
      S_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end && tx_bit_idx == 3'(DATA_W - 1)) tx_next = tx_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_line = tx_par_bit;
        if (tx_bit_end) tx_next = S_STOP;
      end
      S_STOP:   if (tx_bit_end && tx_stop_idx == tx_two_stop) tx_next = S_IDLE;
      default:  tx_next = S_IDLE;
    endcase
  end

  assign tx_pop = (tx_state == S_IDLE) && (tx_next == S_START);
  assign o_tx   = ctrl.loopback | tx_line;

  // Frame options are captured with the byte so a CTRL write cannot corrupt a frame in flight.
  always_ff @(posedge i_sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt      <= '0;
      tx_bit_idx  <= '0;
      tx_shift    <= '0;
      tx_par_en   <= 1'b0;
      tx_two_stop <= 1'b0;
      tx_par_bit  <= 1'b0;
      tx_stop_idx <= 1'b0;
    end else if (tx_pop) begin
      tx_cnt      <= '0;
      tx_bit_idx  <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= tx_dout;
      tx_par_en   <= ctrl.par_en;
      tx_two_stop <= ctrl.two_stop;
      tx_par_bit  <= (^tx_dout) ^ ctrl.par_odd;
    end else if (tx_state != S_IDLE && tick) begin
      tx_cnt <= tx_cnt + 4'd1;
      if (tx_cnt == 4'd15 && tx_state == S_DATA) begin
        tx_shift   <= tx_shift >> 1;
        tx_bit_idx <= tx_bit_idx + 3'd1;
      end
      if (tx_cnt == 4'd15 && tx_state == S_STOP) tx_stop_idx <= 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], ctrl.loopback ? tx_line : i_rx};
  end
  assign rx_s = rx_sync[1];

  // Bits are sampled 16 ticks apart, starting from the mid-start check at tick 8.
  assign rx_sample = tick && (rx_cnt == 4'd15);
  assign rx_done   = (rx_state == S_STOP) && rx_sample && ctrl.rx_en;
  assign rx_good   = rx_done & rx_s & ~rx_par_bad;

  always_ff @(posedge i_sys_clk or negedge rst_n) begin
    if (!rst_n) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:   if (!rx_s) rx_next = S_START;
      S_START:  if (tick && rx_cnt == 4'd7) rx_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (rx_sample && rx_bit_idx == 3'(DATA_W - 1)) rx_next = ctrl.par_en ? S_PARITY : S_STOP;
      S_PARITY: if (rx_sample) rx_next = S_STOP;
      S_STOP:   if (rx_sample) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
    if (!ctrl.rx_en) rx_next = S_IDLE;
  end

  always_ff @(posedge i_sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
    end else if (rx_state == S_IDLE) begin
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_par_bad <= 1'b0;
    end else if (tick) begin
      rx_cnt <= (rx_state == S_START && rx_cnt == 4'd7) ? 4'd0 : rx_cnt + 4'd1;
      if (rx_sample && rx_state == S_DATA) begin
        rx_shift   <= {rx_s, rx_shift[DATA_W-1:1]};
        rx_bit_idx <= rx_bit_idx + 3'd1;
      end
      if (rx_sample && rx_state == S_PARITY) rx_par_bad <= rx_s ^ (^rx_shift) ^ ctrl.par_odd;
    end
  end
endmodule
